// File: rtl/fifo_junction_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_junction_rr: N-client round-robin junction onto one device FIFO pair |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fifo_junction_rr #(
  parameter int CLIENTS    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_HOLD   = 0
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [CLIENTS-1:0]              req,
  output logic [CLIENTS-1:0]              grant,
  output logic                            busy,
  output logic                            stray_strobe,
  input  logic [CLIENTS-1:0]              cl_rx_read,
  input  logic [CLIENTS-1:0]              cl_tx_write,
  input  logic [CLIENTS*DATA_WIDTH-1:0]   cl_tx_wdata,
  output logic [CLIENTS-1:0]              cl_rx_empty,
  output logic [CLIENTS-1:0]              cl_rx_almost_empty,
  output logic [CLIENTS-1:0]              cl_tx_full,
  output logic [CLIENTS-1:0]              cl_tx_almost_full,
  output logic [DATA_WIDTH-1:0]           cl_rx_rdata,
  output logic                            dev_rx_read,
  output logic                            dev_tx_write,
  output logic [DATA_WIDTH-1:0]           dev_tx_wdata,
  input  logic                            dev_rx_empty,
  input  logic                            dev_rx_almost_empty,
  input  logic                            dev_tx_full,
  input  logic                            dev_tx_almost_full,
  input  logic [DATA_WIDTH-1:0]           dev_rx_rdata
);

  localparam int PTR_W  = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;
  localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(CLIENTS - 1);
  localparam logic [PTR_W:0]    CLIENTS_W = (PTR_W + 1)'(CLIENTS);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [CLIENTS-1:0]   grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic                 stray_q, stray_d;

  logic [PTR_W:0]       cand_sum;
  logic [PTR_W-1:0]     cand;
  logic                 found;
  logic [PTR_W-1:0]     next_owner;
  logic                 others_waiting;

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    ptr_d          = ptr_q;
    hold_d         = hold_q;
    grant_d        = grant_q;
    found          = 1'b0;
    cand_sum       = '0;
    cand           = '0;
    next_owner     = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
    others_waiting = |(req & ~grant_q);

    case (state_q)
      ST_IDLE: begin
        // Scan ptr, ptr+1, ... wrapping; first requester wins.
        for (int k = 0; k < CLIENTS; k++) begin
          cand_sum = {1'b0, ptr_q} + (PTR_W + 1)'(k);
          if (cand_sum >= CLIENTS_W) begin
            cand_sum = cand_sum - CLIENTS_W;
          end
          cand = cand_sum[PTR_W-1:0];
          if (!found && req[cand]) begin
            found   = 1'b1;
            owner_d = cand;
          end
        end
        if (found) begin
          state_d = ST_OWNED;
          grant_d = CLIENTS'(1) << owner_d;
          hold_d  = '0;
        end
      end
      ST_OWNED: begin
        if (!req[owner_q] ||
            ((MAX_HOLD > 0) && (hold_q == HOLD_LAST) && others_waiting)) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = next_owner;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase

    busy_d  = |grant_d;
    stray_d = |((cl_rx_read | cl_tx_write) & ~grant_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      stray_q <= stray_d;
    end
  end

  assign grant        = grant_q;
  assign busy         = busy_q;
  assign stray_strobe = stray_q;

  assign dev_rx_read  = |(cl_rx_read & grant_q);
  assign dev_tx_write = |(cl_tx_write & grant_q);

  always_comb begin
    dev_tx_wdata = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      dev_tx_wdata = dev_tx_wdata |
                     (cl_tx_wdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_q[i]}});
    end
  end

  // Non-granted clients see an empty rx side and a full tx side.
  assign cl_rx_empty        = ~grant_q | {CLIENTS{dev_rx_empty}};
  assign cl_rx_almost_empty = ~grant_q | {CLIENTS{dev_rx_almost_empty}};
  assign cl_tx_full         = ~grant_q | {CLIENTS{dev_tx_full}};
  assign cl_tx_almost_full  = ~grant_q | {CLIENTS{dev_tx_almost_full}};
  assign cl_rx_rdata        = dev_rx_rdata;

endmodule
`default_nettype wire

// File: tb/tb_fifo_junction_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fifo_junction_rr: directed bench, 3 clients, hold limit of 4          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fifo_junction_rr;

  localparam int CLIENTS    = 3;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_HOLD   = 4;

  logic                          clk = 1'b0;
  logic                          reset_n;
  logic [CLIENTS-1:0]            req;
  logic [CLIENTS-1:0]            grant;
  logic                          busy;
  logic                          stray_strobe;
  logic [CLIENTS-1:0]            cl_rx_read;
  logic [CLIENTS-1:0]            cl_tx_write;
  logic [CLIENTS*DATA_WIDTH-1:0] cl_tx_wdata;
  logic [CLIENTS-1:0]            cl_rx_empty;
  logic [CLIENTS-1:0]            cl_rx_almost_empty;
  logic [CLIENTS-1:0]            cl_tx_full;
  logic [CLIENTS-1:0]            cl_tx_almost_full;
  logic [DATA_WIDTH-1:0]         cl_rx_rdata;
  logic                          dev_rx_read;
  logic                          dev_tx_write;
  logic [DATA_WIDTH-1:0]         dev_tx_wdata;
  logic                          dev_rx_empty;
  logic                          dev_rx_almost_empty;
  logic                          dev_tx_full;
  logic                          dev_tx_almost_full;
  logic [DATA_WIDTH-1:0]         dev_rx_rdata;

  int total = 0;
  int bad   = 0;

  fifo_junction_rr #(
    .CLIENTS    (CLIENTS),
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_HOLD   (MAX_HOLD)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .req                 (req),
    .grant               (grant),
    .busy                (busy),
    .stray_strobe        (stray_strobe),
    .cl_rx_read          (cl_rx_read),
    .cl_tx_write         (cl_tx_write),
    .cl_tx_wdata         (cl_tx_wdata),
    .cl_rx_empty         (cl_rx_empty),
    .cl_rx_almost_empty  (cl_rx_almost_empty),
    .cl_tx_full          (cl_tx_full),
    .cl_tx_almost_full   (cl_tx_almost_full),
    .cl_rx_rdata         (cl_rx_rdata),
    .dev_rx_read         (dev_rx_read),
    .dev_tx_write        (dev_tx_write),
    .dev_tx_wdata        (dev_tx_wdata),
    .dev_rx_empty        (dev_rx_empty),
    .dev_rx_almost_empty (dev_rx_almost_empty),
    .dev_tx_full         (dev_tx_full),
    .dev_tx_almost_full  (dev_tx_almost_full),
    .dev_rx_rdata        (dev_rx_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Grant sequence for two clients contending under a hold limit of 4.
  logic [CLIENTS-1:0] rot_exp [11] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000,
                                      3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b001};

  initial begin
    reset_n             = 1'b0;
    req                 = '0;
    cl_rx_read          = '0;
    cl_tx_write         = '0;
    cl_tx_wdata         = {8'h33, 8'hA5, 8'h5A};
    dev_rx_empty        = 1'b0;
    dev_rx_almost_empty = 1'b0;
    dev_tx_full         = 1'b0;
    dev_tx_almost_full  = 1'b0;
    dev_rx_rdata        = 8'h3C;
    tick();
    tick();
    reset_n = 1'b1;

    // Idle after reset: everything masked, nothing forwarded.
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_grant", 32'(grant), 32'h0);
    end
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_rx_empty", 32'(cl_rx_empty), 32'h7);
    chk("idle_tx_full", 32'(cl_tx_full), 32'h7);
    chk("idle_dev_rd", 32'(dev_rx_read), 32'h0);
    chk("idle_dev_wr", 32'(dev_tx_write), 32'h0);
    chk("idle_wdata", 32'(dev_tx_wdata), 32'h0);
    chk("idle_stray", 32'(stray_strobe), 32'h0);

    // Handover: 0 owns, releases, 2 takes over after one idle cycle.
    req = 3'b101;
    tick();
    chk("ho_grant0", 32'(grant), 32'h1);
    chk("ho_busy", 32'(busy), 32'h1);
    chk("ho_rx_empty", 32'(cl_rx_empty), 32'h6);
    chk("ho_tx_full", 32'(cl_tx_full), 32'h6);
    tick();
    req = 3'b100;
    tick();
    chk("ho_gap", 32'(grant), 32'h0);
    chk("ho_gap_busy", 32'(busy), 32'h0);
    tick();
    chk("ho_grant2", 32'(grant), 32'h4);
    req = 3'b000;
    tick();
    chk("ho_release2", 32'(grant), 32'h0);
    // ptr wrapped to 0, so client 0 beats client 1.
    req = 3'b011;
    tick();
    chk("ho_wrap_win0", 32'(grant), 32'h1);
    req = 3'b010;
    tick();
    chk("ho_gap2", 32'(grant), 32'h0);
    tick();
    chk("ho_grant1", 32'(grant), 32'h2);

    // Datapath with client 1 owning; client 0 strobes out of turn.
    cl_tx_write = 3'b011;
    #1;
    chk("dp_tx_write", 32'(dev_tx_write), 32'h1);
    chk("dp_tx_wdata", 32'(dev_tx_wdata), 32'hA5);
    chk("dp_tx_full", 32'(cl_tx_full), 32'h5);
    tick();
    chk("dp_stray", 32'(stray_strobe), 32'h1);
    cl_tx_write = 3'b010;
    tick();
    chk("dp_no_stray", 32'(stray_strobe), 32'h0);
    cl_tx_write = 3'b000;
    cl_rx_read  = 3'b001;
    #1;
    chk("dp_rd_masked", 32'(dev_rx_read), 32'h0);
    cl_rx_read = 3'b010;
    #1;
    chk("dp_rd_owner", 32'(dev_rx_read), 32'h1);
    chk("dp_rdata", 32'(cl_rx_rdata), 32'h3C);
    dev_rx_almost_empty = 1'b1;
    dev_tx_almost_full  = 1'b0;
    #1;
    chk("dp_rx_aempty", 32'(cl_rx_almost_empty), 32'h7);
    chk("dp_tx_afull", 32'(cl_tx_almost_full), 32'h5);
    cl_rx_read = 3'b000;
    req        = 3'b000;
    tick();
    chk("dp_release", 32'(grant), 32'h0);

    // Forced rotation: ptr=2 now, clients 0 and 1 both hold req.
    req = 3'b011;
    for (int c = 0; c < 11; c++) begin
      tick();
      chk($sformatf("rot_%0d", c), 32'(grant), 32'(rot_exp[c]));
    end
    req = 3'b000;
    tick();
    chk("rot_release", 32'(grant), 32'h0);
    tick();

    // Lone requester keeps the grant past the hold limit.
    req = 3'b100;
    tick();
    chk("solo_grant", 32'(grant), 32'h4);
    for (int c = 0; c < 22; c++) begin
      tick();
      chk("solo_hold", 32'(grant), 32'h4);
    end

    // Asynchronous reset in the middle of an rx burst.
    cl_rx_read = 3'b100;
    #1;
    chk("rst_pre_rd", 32'(dev_rx_read), 32'h1);
    #1;
    reset_n    = 1'b0;
    cl_rx_read = 3'b000;
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_dev_rd", 32'(dev_rx_read), 32'h0);
    cl_rx_read = 3'b100;
    #1;
    chk("rst_dev_rd_masked", 32'(dev_rx_read), 32'h0);
    cl_rx_read = 3'b000;
    req        = 3'b000;
    tick();
    reset_n = 1'b1;
    tick();
    chk("rst_post_grant", 32'(grant), 32'h0);
    chk("rst_post_stray", 32'(stray_strobe), 32'h0);
    // ptr back at 0: client 0 wins over client 1.
    req = 3'b011;
    tick();
    chk("rst_ptr0", 32'(grant), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
